div_rem_issue_ctrl: RTL and testbench
=====================================

// Module: div_rem_issue_ctrl
// PURPOSE
//  Sequencing stage directly upstream of the div/rem functional unit.
//  - Accepts one DIV/DIVU/REM/REMU op from the mult/div reservation station (valid/ready).
//  - Latches operands and tags, drives the sequential divider's start/operands, and times
//    completion with a cycle counter.
//  - Applies RISC-V div-by-zero/overflow semantics and holds the result for the CDB until accepted.
// PARAMETERS
//  PHYS_REG_BITS  6  width of destination physical register tag
//  ROB_IDX_BITS   5  width of ROB index tag
//  DIV_CYCLES     3  divider latency, start pulse to valid quotient/remainder (>=1)
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous active-high reset
//  flush          in   1              kill in-flight op (branch mispredict)
//  iss_valid      in   1              RS presents an op
//  iss_ready      out  1              ctrl can accept (IDLE only)
//  iss_funct3     in   3              mult_div_f3_div/divu/rem/remu
//  iss_rs1_v      in   32             dividend
//  iss_rs2_v      in   32             divisor
//  iss_pd         in   PHYS_REG_BITS  destination phys reg
//  iss_rob_idx    in   ROB_IDX_BITS   ROB entry
//  div_start      out  1              one-cycle start pulse to divider
//  div_a, div_b   out  33             sign/zero-extended operands, stable START..capture
//  div_complete   in   1              divider complete flag (also high when idle)
//  div_quotient   in   33             divider quotient
//  div_remainder  in   33             divider remainder
//  cdb_valid      out  1              result valid to CDB arbiter
//  cdb_ready      in   1              arbiter accepts this cycle
//  cdb_pd         out  PHYS_REG_BITS  result tag
//  cdb_rob_idx    out  ROB_IDX_BITS   result ROB index
//  cdb_rd_v       out  32             result value
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, iss_ready=0 during rst then 1, div_start=0, cdb_valid=0,
//    cdb_pd/rob_idx/rd_v=0, div_a/div_b=0.
//  - FSM IDLE->START->BUSY->DONE->IDLE; DRAIN for flush.
//  - IDLE: iss_ready=1; on iss_valid, latch funct3/ops/tags, go START.
//    * signed (div/rem): a={rs1[31],rs1}, b={rs2[31],rs2}; unsigned: a={1'b0,rs1}, b={1'b0,rs2}.
//  - START: div_start=1 for exactly one cycle, cnt<=0, go BUSY.
//  - BUSY: cnt++ each cycle. div_complete is ignored until cnt==DIV_CYCLES-1. When
//    cnt==DIV_CYCLES-1 and div_complete, capture the result and go DONE.
//    * div/divu -> quotient[31:0]; rem/remu -> remainder[31:0].
//  - Special cases, overriding the divider output at capture:
//    * divisor==0: quotient=32'hFFFF_FFFF, remainder=rs1.
//    * signed rs1==32'h8000_0000 and rs2==32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
//  - DONE: cdb_valid=1 with stable tags/value until cdb_ready; on cdb_ready go IDLE.
//    * Next op is accepted no earlier than the following cycle (no same-cycle reissue).
//  - Issue-to-CDB latency: DIV_CYCLES+2 cycles minimum (issue edge, START, BUSY x DIV_CYCLES).
//  - flush:
//    * IDLE: no effect; an op presented the same cycle is dropped.
//    * START or BUSY: discard the op and go DRAIN. DRAIN holds iss_ready=0, waits until
//      cnt==DIV_CYCLES-1 && div_complete, then goes IDLE.
//    * DONE: cdb_valid drops next cycle, go IDLE. If cdb_ready is high the same cycle,
//      the handshake completes and flush still wins (ROB discards).
//  - Reset mid-operation: immediate return to reset values; divider's own reset clears it.
//  - Funct3 of mul class never issued here; if seen, treated as divu (no hang).
// CONFIGURATION
//  DIV_FAST_PATH_EN defined:
//   - divisor==0 or signed overflow detected in IDLE at issue goes START->DONE directly.
//     div_start is still not pulsed, and the special-case result appears in DONE.
//     Latency is 2 cycles.
//  DIV_FAST_PATH_EN undefined:
//   - special cases take the full divider path and are overridden at capture.
//     Latency is DIV_CYCLES+2.
// STRUCTURE
//  - Shared package (rv32i_types):
//    * div_ctrl_state_t enum {IDLE,START,BUSY,DONE,DRAIN}.
//    * div_req_t struct {funct3, rs1_v, rs2_v, pd, rob_idx}.
//    * Existing mult_div_f3_* constants.
//  - One sub-module: div_special_case (combinational): rs1, rs2, funct3 -> is_special,
//    special_val.
//  - Divider instance lives in the functional unit, not here.
// TESTING
//  - DIV_CYCLES=3, div 100/7 signed, cdb_ready=1 -> div_start pulse 1 cycle after issue;
//    cdb_rd_v=14 on cycle 5; REM 100/7 -> 2.
//  - div -7/2 -> 32'hFFFF_FFFD; rem -7/2 -> 32'hFFFF_FFFF; divu 32'hFFFF_FFFF/2 -> 32'h7FFF_FFFF.
//  - divu 5/0 -> 32'hFFFF_FFFF; rem 5/0 -> 5; div 32'h8000_0000/-1 -> 32'h8000_0000, rem -> 0.
//    With DIV_FAST_PATH_EN: no div_start, result 2 cycles after issue.
//  - cdb_ready held 0 for 4 cycles in DONE -> cdb_valid, pd, rob_idx, rd_v stable;
//    iss_ready=0 throughout; release -> IDLE next cycle.
//  - flush in cycle 2 of BUSY -> no cdb_valid ever; iss_ready=0 until divider completes.
//    A new op issued afterward returns the correct result.
//  - rst asserted in BUSY -> next cycle all outputs at reset values, iss_ready=1 after rst drops.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32 type package: mult/div funct3 encodings, the div/rem issue
// controller state enum and request struct, plus small funct3 decode helpers.
package rv32i_types;

  localparam logic [2:0] mult_div_f3_mul    = 3'b000;
  localparam logic [2:0] mult_div_f3_mulh   = 3'b001;
  localparam logic [2:0] mult_div_f3_mulhsu = 3'b010;
  localparam logic [2:0] mult_div_f3_mulhu  = 3'b011;
  localparam logic [2:0] mult_div_f3_div    = 3'b100;
  localparam logic [2:0] mult_div_f3_divu   = 3'b101;
  localparam logic [2:0] mult_div_f3_rem    = 3'b110;
  localparam logic [2:0] mult_div_f3_remu   = 3'b111;

  // Tag fields in the request struct are sized for the widest configuration;
  // each instance uses only the low PHYS_REG_BITS / ROB_IDX_BITS bits.
  localparam int DIV_TAG_MAX_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BUSY  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } div_ctrl_state_t;

  typedef struct packed {
    logic [2:0]                  funct3;
    logic [31:0]                 rs1_v;
    logic [31:0]                 rs2_v;
    logic [DIV_TAG_MAX_BITS-1:0] pd;
    logic [DIV_TAG_MAX_BITS-1:0] rob_idx;
  } div_req_t;

  // A mul-class funct3 should never reach the divider; treat it as divu so
  // the sequencer still terminates.
  function automatic logic [2:0] div_f3_normalize(input logic [2:0] f3);
    case (f3)
      mult_div_f3_mul, mult_div_f3_mulh,
      mult_div_f3_mulhsu, mult_div_f3_mulhu: return mult_div_f3_divu;
      default:                               return f3;
    endcase
  endfunction

  function automatic logic div_f3_is_signed(input logic [2:0] f3);
    return (f3 == mult_div_f3_div) || (f3 == mult_div_f3_rem);
  endfunction

  function automatic logic div_f3_is_rem(input logic [2:0] f3);
    return (f3 == mult_div_f3_rem) || (f3 == mult_div_f3_remu);
  endfunction

endpackage

// File: rtl/div_special_case.sv
// RISC-V division special cases: divide-by-zero and signed overflow
// (most-negative / -1). Purely combinational; the result overrides the
// divider output whenever is_special_o is set.
module div_special_case
  import rv32i_types::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  output logic        is_special_o,
  output logic [31:0] special_val_o
);

  logic [2:0] f3;
  logic       div_by_zero;
  logic       overflow;
  logic       is_rem;

  // Detect the two architecturally defined corner cases and form their result.
  always_comb begin
    f3            = div_f3_normalize(funct3_i);
    is_rem        = div_f3_is_rem(f3);
    div_by_zero   = (rs2_i == 32'h0000_0000);
    overflow      = div_f3_is_signed(f3) && (rs1_i == 32'h8000_0000) &&
                    (rs2_i == 32'hFFFF_FFFF);
    is_special_o  = div_by_zero | overflow;
    special_val_o = 32'h0000_0000;
    if (div_by_zero) begin
      special_val_o = is_rem ? rs1_i : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_val_o = is_rem ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

endmodule

// File: rtl/div_rem_issue_ctrl.sv
// Sequencing stage in front of the sequential div/rem unit. Accepts one op
// from the mult/div reservation station, starts the divider, times completion
// with a cycle counter, applies RISC-V special-case results and holds the
// result for the CDB until accepted. A branch flush kills the op in flight.
//
// Build option: define DIV_FAST_PATH_EN to send divide-by-zero and signed
// overflow straight from START to DONE without starting the divider.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high (iss_valid/iss_ready in, cdb_valid/cdb_ready out); once
// cdb_valid is raised, tags and value stay constant until that edge.
module div_rem_issue_ctrl
  import rv32i_types::*;
#(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5,
  parameter int DIV_CYCLES    = 3
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [2:0]               iss_funct3,
  input  logic [31:0]              iss_rs1_v,
  input  logic [31:0]              iss_rs2_v,
  input  logic [PHYS_REG_BITS-1:0] iss_pd,
  input  logic [ROB_IDX_BITS-1:0]  iss_rob_idx,
  output logic                     div_start,
  output logic [32:0]              div_a,
  output logic [32:0]              div_b,
  input  logic                     div_complete,
  input  logic [32:0]              div_quotient,
  input  logic [32:0]              div_remainder,
  output logic                     cdb_valid,
  input  logic                     cdb_ready,
  output logic [PHYS_REG_BITS-1:0] cdb_pd,
  output logic [ROB_IDX_BITS-1:0]  cdb_rob_idx,
  output logic [31:0]              cdb_rd_v,
  output div_ctrl_state_t          dbg_state
);

  localparam int CNT_BITS = (DIV_CYCLES < 2) ? 1 : $clog2(DIV_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DIV_CYCLES - 1);

`ifdef DIV_FAST_PATH_EN
  localparam bit FAST_PATH = 1'b1;
`else
  localparam bit FAST_PATH = 1'b0;
`endif

  div_ctrl_state_t           state_q;
  logic [CNT_BITS-1:0]       cnt_q;
  div_req_t                  req_q;
  logic                      fast_q;
  logic                      div_start_q;
  logic [32:0]               div_a_q;
  logic [32:0]               div_b_q;
  logic                      cdb_valid_q;
  logic [PHYS_REG_BITS-1:0]  cdb_pd_q;
  logic [ROB_IDX_BITS-1:0]   cdb_rob_idx_q;
  logic [31:0]               cdb_rd_v_q;

  div_req_t                  req_d;
  logic [32:0]               div_a_d;
  logic [32:0]               div_b_d;
  logic                      fast_d;
  logic [31:0]               result_d;
  logic [CNT_BITS-1:0]       cnt_d;
  logic                      cnt_last;

  logic [31:0]               sc_rs1;
  logic [31:0]               sc_rs2;
  logic [2:0]                sc_funct3;
  logic                      sc_is_special;
  logic [31:0]               sc_val;

  // In IDLE the special-case check looks at the incoming op (fast-path
  // decision at issue); afterwards it looks at the latched op.
  always_comb begin
    if (state_q == IDLE) begin
      sc_rs1    = iss_rs1_v;
      sc_rs2    = iss_rs2_v;
      sc_funct3 = div_f3_normalize(iss_funct3);
    end else begin
      sc_rs1    = req_q.rs1_v;
      sc_rs2    = req_q.rs2_v;
      sc_funct3 = req_q.funct3;
    end
  end

  div_special_case u_special (
    .rs1_i         (sc_rs1),
    .rs2_i         (sc_rs2),
    .funct3_i      (sc_funct3),
    .is_special_o  (sc_is_special),
    .special_val_o (sc_val)
  );

  // Next-request formation, operand extension, result selection and the
  // saturating cycle counter.
  always_comb begin
    req_d.funct3  = div_f3_normalize(iss_funct3);
    req_d.rs1_v   = iss_rs1_v;
    req_d.rs2_v   = iss_rs2_v;
    req_d.pd      = DIV_TAG_MAX_BITS'(iss_pd);
    req_d.rob_idx = DIV_TAG_MAX_BITS'(iss_rob_idx);
    if (div_f3_is_signed(req_d.funct3)) begin
      div_a_d = {iss_rs1_v[31], iss_rs1_v};
      div_b_d = {iss_rs2_v[31], iss_rs2_v};
    end else begin
      div_a_d = {1'b0, iss_rs1_v};
      div_b_d = {1'b0, iss_rs2_v};
    end
    fast_d = FAST_PATH && sc_is_special;
    if (sc_is_special) begin
      result_d = sc_val;
    end else if (div_f3_is_rem(req_q.funct3)) begin
      result_d = div_remainder[31:0];
    end else begin
      result_d = div_quotient[31:0];
    end
    cnt_last = (cnt_q == CNT_LAST);
    cnt_d    = cnt_last ? cnt_q : cnt_q + CNT_BITS'(1);
  end

  // Issue/complete sequencer; all outputs except iss_ready are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_q         <= '0;
      fast_q        <= 1'b0;
      div_start_q   <= 1'b0;
      div_a_q       <= '0;
      div_b_q       <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_pd_q      <= '0;
      cdb_rob_idx_q <= '0;
      cdb_rd_v_q    <= '0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A flush in the issue cycle drops the presented op.
          if (iss_valid && !flush) begin
            req_q       <= req_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            fast_q      <= fast_d;
            div_start_q <= !fast_d;
            state_q     <= START;
          end
        end
        START: begin
          cnt_q <= '0;
          if (flush) begin
            state_q <= DRAIN;
          end else if (fast_q) begin
            cdb_valid_q   <= 1'b1;
            cdb_pd_q      <= req_q.pd[PHYS_REG_BITS-1:0];
            cdb_rob_idx_q <= req_q.rob_idx[ROB_IDX_BITS-1:0];
            cdb_rd_v_q    <= result_d;
            state_q       <= DONE;
          end else begin
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            cnt_q   <= cnt_d;
            state_q <= DRAIN;
          end else if (cnt_last && div_complete) begin
            cdb_valid_q   <= 1'b1;
            cdb_pd_q      <= req_q.pd[PHYS_REG_BITS-1:0];
            cdb_rob_idx_q <= req_q.rob_idx[ROB_IDX_BITS-1:0];
            cdb_rd_v_q    <= result_d;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DRAIN: begin
          // Let the killed divide finish so the next op sees a clean divider.
          if (cnt_last && div_complete) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          if (flush || cdb_ready) begin
            cdb_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{div_quotient[32], div_remainder[32], req_q.pd, req_q.rob_idx};

  assign iss_ready   = (state_q == IDLE) && !rst;
  assign div_start   = div_start_q;
  assign div_a       = div_a_q;
  assign div_b       = div_b_q;
  assign cdb_valid   = cdb_valid_q;
  assign cdb_pd      = cdb_pd_q;
  assign cdb_rob_idx = cdb_rob_idx_q;
  assign cdb_rd_v    = cdb_rd_v_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_div_rem_issue_ctrl.sv
// Self-checking bench for div_rem_issue_ctrl: behavioural divider model,
// directed corner cases, flush/reset scenarios and randomized ops checked
// against an arithmetic reference of the RISC-V div/rem rules.
module tb_div_rem_issue_ctrl;
  import rv32i_types::*;

  localparam int PRB = 6;
  localparam int RIB = 5;
  localparam int DC  = 3;
  localparam int EW  = PRB + RIB + 32;

`ifdef DIV_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            iss_valid = 1'b0;
  logic            iss_ready;
  logic [2:0]      iss_funct3 = '0;
  logic [31:0]     iss_rs1_v = '0;
  logic [31:0]     iss_rs2_v = '0;
  logic [PRB-1:0]  iss_pd = '0;
  logic [RIB-1:0]  iss_rob_idx = '0;
  logic            div_start;
  logic [32:0]     div_a;
  logic [32:0]     div_b;
  logic            div_complete;
  logic [32:0]     div_quotient;
  logic [32:0]     div_remainder;
  logic            cdb_valid;
  logic            cdb_ready = 1'b0;
  logic [PRB-1:0]  cdb_pd;
  logic [RIB-1:0]  cdb_rob_idx;
  logic [31:0]     cdb_rd_v;
  div_ctrl_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  int cur_lat = 0;
  int cur_starts = 0;
  int extra_lat = 0;

  div_rem_issue_ctrl #(.PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_funct3(iss_funct3),
    .iss_rs1_v(iss_rs1_v), .iss_rs2_v(iss_rs2_v), .iss_pd(iss_pd), .iss_rob_idx(iss_rob_idx),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_complete(div_complete),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_pd(cdb_pd),
    .cdb_rob_idx(cdb_rob_idx), .cdb_rd_v(cdb_rd_v), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural sequential divider: valid DIV_CYCLES(+extra) after start.
  logic signed [32:0] dv_sa;
  logic signed [32:0] dv_sb;
  int dv_cnt = 0;
  assign dv_sa = div_a;
  assign dv_sb = div_b;

  always @(posedge clk) begin
    if (rst) begin
      dv_cnt        <= 0;
      div_complete  <= 1'b1;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else if (div_start) begin
      if (dv_sb == 0) begin
        div_quotient  <= 33'($urandom);
        div_remainder <= 33'($urandom);
      end else begin
        div_quotient  <= dv_sa / dv_sb;
        div_remainder <= dv_sa % dv_sb;
      end
      dv_cnt       <= DC - 1 + extra_lat;
      div_complete <= ((DC - 1 + extra_lat) == 0);
    end else if (dv_cnt > 0) begin
      dv_cnt       <= dv_cnt - 1;
      div_complete <= (dv_cnt == 1);
    end
  end

  // Reference: RISC-V M-extension division rules in plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    bit sgn;
    bit rem;
    int sa;
    int sb;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    rem = (f3 == 3'b110) || (f3 == 3'b111);
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin
      sa = a;
      sb = b;
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? (a % b) : (a / b);
  endfunction

  function automatic bit ref_special(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sgn;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: present one op for one cycle; returns in the cycle after issue.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int extra, input logic [31:0] expv);
    int w;
    logic [PRB-1:0] pd;
    logic [RIB-1:0] rob;
    w = 0;
    while (iss_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    chk("issue_ready", iss_ready, 1);
    pd          = PRB'($urandom);
    rob         = RIB'($urandom);
    iss_valid   = 1'b1;
    iss_funct3  = f3;
    iss_rs1_v   = a;
    iss_rs2_v   = b;
    iss_pd      = pd;
    iss_rob_idx = rob;
    extra_lat   = extra;
    if (FAST && ref_special(f3, a, b)) begin
      cur_lat    = 2;
      cur_starts = 0;
    end else begin
      cur_lat    = DC + 2 + extra;
      cur_starts = 1;
    end
    exp_q.push_back({pd, rob, expv});
    tick();
    iss_valid = 1'b0;
  endtask

  // Wait for the result, check it, hold cdb_ready low for 'hold' cycles, accept.
  task automatic collect(input int hold);
    int cyc;
    int starts;
    bit ready_bad;
    bit hold_bad;
    logic [EW-1:0] e;
    cyc = 1;
    starts = 0;
    ready_bad = 1'b0;
    hold_bad = 1'b0;
    e = '0;
    while (cdb_valid !== 1'b1 && cyc < 60) begin
      if (div_start === 1'b1) starts++;
      if (iss_ready !== 1'b0) ready_bad = 1'b1;
      tick();
      cyc++;
    end
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("start_pulses", starts, cur_starts);
    chk("latency", cyc, cur_lat);
    chk("ready_low_busy", ready_bad, 0);
    chk("cdb_pd", cdb_pd, e[EW-1 -: PRB]);
    chk("cdb_rob_idx", cdb_rob_idx, e[32 +: RIB]);
    chk("cdb_rd_v", cdb_rd_v, e[31:0]);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (cdb_valid !== 1'b1 || {cdb_pd, cdb_rob_idx, cdb_rd_v} !== e || iss_ready !== 1'b0)
        hold_bad = 1'b1;
    end
    chk("hold_stable", hold_bad, 0);
    cdb_ready = 1'b1;
    tick();
    cdb_ready = 1'b0;
    chk("cdb_drop", cdb_valid, 0);
    chk("ready_after", iss_ready, 1);
  endtask

  // Directed corner cases with hand-computed results.
  logic [2:0]  d_f3 [11] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b101,
                             3'b110, 3'b100, 3'b110, 3'b001, 3'b111};
  logic [31:0] d_a  [11] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF,
                             32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0,
                             32'hFFFF_FFFF};
  logic [31:0] d_b  [11] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd0};
  logic [31:0] d_exp[11] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'h5555_5550,
                             32'hFFFF_FFFF};

  initial begin
    int cyc;
    bit seen;
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] b;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_iss_ready", iss_ready, 0);
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    chk("rst_cdb_rd_v", cdb_rd_v, 0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", iss_ready, 1);

    // Directed ops, result accepted immediately
    for (int i = 0; i < 11; i++) begin
      issue(d_f3[i], d_a[i], d_b[i], 0, d_exp[i]);
      collect(0);
    end

    // Backpressure: cdb_ready low for 4 cycles in DONE
    issue(3'b100, 32'd1234, 32'd10, 0, 32'd123);
    collect(4);

    // Flush in IDLE together with a presented op: op dropped
    iss_valid = 1'b1; iss_funct3 = 3'b100; iss_rs1_v = 32'd9; iss_rs2_v = 32'd3;
    flush = 1'b1;
    tick();
    iss_valid = 1'b0;
    flush = 1'b0;
    chk("idle_flush_state", dbg_state, IDLE);
    chk("idle_flush_start", div_start, 0);
    seen = 1'b0;
    for (int i = 0; i < DC + 3; i++) begin
      if (cdb_valid === 1'b1) seen = 1'b1;
      tick();
    end
    chk("idle_flush_no_cdb", seen, 0);

    // Flush in the second BUSY cycle, divider one cycle slower than minimum
    issue(3'b100, 32'd1000, 32'd3, 1, 32'd333);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(exp_q.pop_back());
    cyc = 4;
    seen = 1'b0;
    while (iss_ready !== 1'b1 && cyc < 60) begin
      if (cdb_valid === 1'b1) seen = 1'b1;
      tick();
      cyc++;
    end
    chk("busy_flush_no_cdb", seen, 0);
    chk("busy_flush_drain_len", cyc, DC + 3);
    issue(3'b110, 32'd1000, 32'd3, 0, 32'd1);
    collect(0);

    // Flush in DONE, with and without a same-cycle cdb_ready
    for (int k = 0; k < 2; k++) begin
      issue(3'b100, 32'd50, 32'd5, 0, 32'd10);
      cyc = 1;
      while (cdb_valid !== 1'b1 && cyc < 60) begin
        tick();
        cyc++;
      end
      chk("done_flush_rd_v", cdb_rd_v, 32'd10);
      void'(exp_q.pop_front());
      flush = 1'b1;
      cdb_ready = (k == 1);
      tick();
      flush = 1'b0;
      cdb_ready = 1'b0;
      chk("done_flush_valid", cdb_valid, 0);
      chk("done_flush_ready", iss_ready, 1);
    end

    // Reset in BUSY
    issue(3'b100, 32'd100, 32'd7, 0, 32'd14);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_iss_ready", iss_ready, 0);
    chk("midrst_cdb_valid", cdb_valid, 0);
    chk("midrst_div_start", div_start, 0);
    chk("midrst_div_a", div_a, 0);
    chk("midrst_div_b", div_b, 0);
    chk("midrst_cdb_rd_v", cdb_rd_v, 0);
    chk("midrst_cdb_pd", cdb_pd, 0);
    chk("midrst_state", dbg_state, IDLE);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", iss_ready, 1);
    void'(exp_q.pop_back());
    issue(3'b111, 32'd100, 32'd7, 0, 32'd2);
    collect(0);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 3));
      else f3 = 3'($urandom_range(4, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 10));
        3:       b = -32'($urandom_range(1, 10));
        default: b = $urandom;
      endcase
      issue(f3, a, b, $urandom_range(0, 2), ref_div(f3, a, b));
      collect($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
